mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mips_pkg.sv | 19 +
 rtl/mul_div_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mul/div op codes
// and the mul/div sequencer state encoding.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the hi/lo pair.
// Ports: CLK, RST (async, active-low), start, op[1:0],
//   src_a/src_b[SIZE-1:0] in; busy, done, HLEN (=done),
//   hi_out/lo_out[SIZE-1:0] (registered), dz out.
// Option: MUL_DIV_ZERO_DETECT_EN short-cuts divide by zero
//   straight to FIX with hi=src_a, lo=all ones, dz=1.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] src_a,
  input  logic [SIZE-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic            HLEN,
  output logic [SIZE-1:0] hi_out,
  output logic [SIZE-1:0] lo_out,
  output logic            dz
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  md_state_e state, state_nx;

  logic [CW-1:0]   count;
  logic [SIZE-1:0] acc_hi;
  logic [SIZE-1:0] acc_lo;
  logic [SIZE-1:0] opnd;
  logic            is_div;
  logic            neg_q;
  logic            neg_r;
  logic            dz_pend;

  logic            sgn_op;
  logic            div_op;
  logic            sa;
  logic            sb;
  logic [SIZE-1:0] mag_a;
  logic [SIZE-1:0] mag_b;
  logic            zero_div;

  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign sa     = sgn_op & src_a[SIZE-1];
  assign sb     = sgn_op & src_b[SIZE-1];
  assign mag_a  = sa ? (~src_a + 1'b1) : src_a;
  assign mag_b  = sb ? (~src_b + 1'b1) : src_b;

`ifdef MUL_DIV_ZERO_DETECT_EN
  assign zero_div = div_op && (src_b == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Multiply step: add multiplicand on LSB, shift
  // {carry,hi,lo} right by one.
  logic [SIZE:0]   mul_sum;
  logic [SIZE-1:0] mul_hi_nx;
  logic [SIZE-1:0] mul_lo_nx;

  assign mul_sum   = {1'b0, acc_hi}
                   + (acc_lo[0] ? {1'b0, opnd}
                                : {(SIZE+1){1'b0}});
  assign mul_hi_nx = mul_sum[SIZE:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[SIZE-1:1]};

  // Restoring divide step: remainder in hi, dividend
  // shifting out of lo while quotient bits shift in.
  logic [SIZE:0]   div_sh;
  logic [SIZE+1:0] div_df;
  logic            div_ok;
  logic [SIZE-1:0] div_hi_nx;
  logic [SIZE-1:0] div_lo_nx;

  assign div_sh    = {acc_hi, acc_lo[SIZE-1]};
  assign div_df    = {1'b0, div_sh} - {2'b00, opnd};
  assign div_ok    = ~div_df[SIZE+1];
  assign div_hi_nx = div_ok ? div_df[SIZE-1:0]
                            : div_sh[SIZE-1:0];
  assign div_lo_nx = {acc_lo[SIZE-2:0], div_ok};

  logic [2*SIZE-1:0] prod;
  logic [2*SIZE-1:0] prod_fix;
  logic [SIZE-1:0]   quo_fix;
  logic [SIZE-1:0]   rem_fix;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
  assign quo_fix  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
  assign rem_fix  = neg_r ? (~acc_hi + 1'b1) : acc_hi;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = zero_div ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (count == '0) state_nx = S_FIX;
      end
      S_FIX: state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign HLEN = done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
      dz      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= div_op;
            dz_pend <= zero_div;
            count   <= CW'(SIZE - 1);
            if (zero_div) begin
              // Preload the fixed result; FIX
              // passes it through unsigned.
              acc_hi <= src_a;
              acc_lo <= '1;
              opnd   <= '0;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else begin
              acc_hi <= '0;
              acc_lo <= div_op ? mag_a : mag_b;
              opnd   <= div_op ? mag_b : mag_a;
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
            end
          end
        end
        S_CALC: begin
          count  <= count - 1'b1;
          acc_hi <= is_div ? div_hi_nx : mul_hi_nx;
          acc_lo <= is_div ? div_lo_nx : mul_lo_nx;
        end
        S_FIX: begin
          if (is_div) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end else begin
            hi_out <= prod_fix[2*SIZE-1:SIZE];
            lo_out <= prod_fix[SIZE-1:0];
          end
          dz <= dz_pend;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
